// File: rtl/slt_pkg.sv
// -----------------------------------------------------------------------------
// slt_pkg
// Shared ALU definitions used by the comparison units (slt, sltu, compare).
//   ALU_WIDTH  : datapath width of the 64-bit ALU operation units
//   FLAG_BIT   : bit position that carries a comparison flag in a result word
//   zext_flag  : builds a result word holding a flag in bit 0, zero elsewhere
// -----------------------------------------------------------------------------
package slt_pkg;

   localparam int ALU_WIDTH = 64;
   localparam int FLAG_BIT  = 0;

   // Comparison results are zero-extended: the flag sits in bit 0 and every
   // upper bit is a constant 0.
   function automatic logic [ALU_WIDTH-1:0] zext_flag(input logic flag);
      logic [ALU_WIDTH-1:0] word;
      word           = {ALU_WIDTH{1'b0}};
      word[FLAG_BIT] = flag;
      return word;
   endfunction

endpackage

// File: rtl/slt_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder, the ripple cell of the slt subtractor.
//   a, b  : input  1  addend bits
//   cin   : input  1  carry in
//   sum   : output 1  sum bit
//   cout  : output 1  carry out
// -----------------------------------------------------------------------------
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/slt.sv
// -----------------------------------------------------------------------------
// slt
// Signed set-less-than ALU unit with a one-cycle registered result.
//   clk   : input  1      rising-edge clock
//   reset : input  1      synchronous, active-high; clears Y
//   A     : input  WIDTH  first operand, two's complement
//   B     : input  WIDTH  second operand, two's complement
//   Y     : output WIDTH  registered result, bit 0 = (A <s B), upper bits 0
// -----------------------------------------------------------------------------
module slt
   import slt_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Y
);

   logic [WIDTH-1:0] b_inv_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] carry_s;
   logic             carry_out_unused;
   logic             neg_s;
   logic             ovf_s;
   logic             lt_s;
   logic [WIDTH-1:0] y_d;
   logic [WIDTH-1:0] y_q;

   // A - B is formed as A + ~B + 1; the +1 enters as the chain's carry-in.
   assign b_inv_s    = ~B;
   assign carry_s[0] = 1'b1;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rca
      if (i < WIDTH - 1) begin : g_mid
         full_adder u_fa (
            .a    (A[i]),
            .b    (b_inv_s[i]),
            .cin  (carry_s[i]),
            .sum  (diff_s[i]),
            .cout (carry_s[i+1])
         );
      end else begin : g_msb
         // The final carry has no meaning for a signed compare.
         full_adder u_fa (
            .a    (A[i]),
            .b    (b_inv_s[i]),
            .cin  (carry_s[i]),
            .sum  (diff_s[i]),
            .cout (carry_out_unused)
         );
      end
   end

   // Overflow of A - B: operands of opposite sign (A and ~B share a sign)
   // and the difference sign disagrees with A. N ^ V then gives the true
   // ordering even when the subtraction wraps.
   assign neg_s = diff_s[WIDTH-1];
   assign ovf_s = (A[WIDTH-1] == b_inv_s[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
   assign lt_s  = neg_s ^ ovf_s;

   // Next result word: flag in bit 0, upper bits held at zero.
   always_comb begin
      y_d = zext_flag(lt_s);
   end

   // Result register; reset wins over the update.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_q <= {WIDTH{1'b0}};
      end else begin
         y_q <= y_d;
      end
   end

   assign Y = y_q;

endmodule

// File: tb/tb_slt.sv
// -----------------------------------------------------------------------------
// tb_slt
// Scoreboard bench for slt: each applied operand pair pushes its expected
// result, which is popped and compared one cycle later.
// -----------------------------------------------------------------------------
module tb_slt;

   logic        clk;
   logic        reset;
   logic [63:0] a_s;
   logic [63:0] b_s;
   logic [63:0] y_s;

   int          n_tests;
   int          n_fail;
   logic [63:0] exp_q[$];
   string       tag_q[$];
   logic [63:0] last_exp;
   bit          have_last;

   slt #(.WIDTH(64)) dut (
      .clk   (clk),
      .reset (reset),
      .A     (a_s),
      .B     (b_s),
      .Y     (y_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Drive one pair at the falling edge, verify Y still holds the previous
   // result (no combinational bypass), then compare after the rising edge.
   task automatic apply(input string tag, input logic [63:0] a, input logic [63:0] b, input logic rst);
      logic [63:0] e;
      string       t;
      @(negedge clk);
      a_s   = a;
      b_s   = b;
      reset = rst;
      e     = 64'd0;
      if (!rst) e[0] = ($signed(a) < $signed(b));
      exp_q.push_back(e);
      tag_q.push_back(tag);
      #1;
      if (have_last) check_eq({tag, "_hold"}, y_s, last_exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", tag);
      end else begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq(t, y_s, e);
         last_exp  = e;
         have_last = 1'b1;
      end
   endtask

   initial begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rr;
      logic [63:0] exp_flag;
      n_tests   = 0;
      n_fail    = 0;
      have_last = 1'b0;
      last_exp  = 64'd0;
      reset     = 1'b1;
      a_s       = 64'd0;
      b_s       = 64'd0;

      // Reset held two cycles, then released with the same operands.
      apply("rst0", -64'sd5, 64'sd3, 1'b1);
      apply("rst1", -64'sd5, 64'sd3, 1'b1);
      apply("rst_rel", -64'sd5, 64'sd3, 1'b0);
      // Hand-derived value independent of the scoreboard reference.
      exp_flag = 64'd1;
      check_eq("rst_rel_const", y_s, exp_flag);

      // Basic set.
      apply("pos_gt", 64'sd10, 64'sd5, 1'b0);
      apply("neg_lt_pos", -64'sd5, 64'sd3, 1'b0);
      apply("neg_gt_neg", -64'sd10, -64'sd20, 1'b0);
      exp_flag = 64'd0;
      check_eq("neg_gt_neg_const", y_s, exp_flag);
      apply("neg_lt_neg", -64'sd10, -64'sd5, 1'b0);

      // Equality.
      apply("eq_zero", 64'd0, 64'd0, 1'b0);
      apply("eq_m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      apply("eq_max", 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);

      // Overflow corners.
      apply("ovf_min_1", 64'h8000_0000_0000_0000, 64'd1, 1'b0);
      exp_flag = 64'd1;
      check_eq("ovf_min_1_const", y_s, exp_flag);
      apply("ovf_max_m1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      exp_flag = 64'd0;
      check_eq("ovf_max_m1_const", y_s, exp_flag);
      apply("ovf_min_max", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      apply("ovf_max_min", 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);

      // Latency: alternate lt / not-lt every cycle.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) apply("lat_lt", 64'(i) - 64'd3, 64'(i), 1'b0);
         else            apply("lat_ge", 64'(i) + 64'd7, -64'sd2, 1'b0);
      end

      // Random pairs with occasional reset pulses; some operands biased to
      // the sign boundary and to equality.
      for (int i = 0; i < 10000; i++) begin
         ra = {$urandom, $urandom};
         rb = {$urandom, $urandom};
         case ($urandom_range(0, 7))
            0:       rb = ra;
            1:       ra[63:1] = {63{ra[63]}};
            2:       rb = ra ^ 64'h8000_0000_0000_0000;
            default: ;
         endcase
         rr = ($urandom_range(0, 49) == 0);
         apply(rr ? "rand_rst" : "rand", ra, rb, rr);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/slt.md
# slt

64-bit signed set-less-than unit for the processor ALU datapath. Compares two 64-bit two's-complement operands and produces a 64-bit result of 1 when A < B (signed), else 0. The result is registered, so the block sits as a one-cycle pipelined ALU function alongside the other 64-bit operation units.

## Interface
Parameters:
- WIDTH, 64, operand and result width in bits; only 64 is required to be verified.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  reset is synchronous and active-high.
- A  input  64  first operand, two's-complement signed.
- B  input  64  second operand, two's-complement signed.
- Y  output  64  registered result: bit 0 = (A <s B), bits 63:1 = 0.

## Operation
- Signed comparison only; no unsigned mode.
- Computed by subtraction: D = A + ~B + 1 over the full 64 bits using a ripple chain of full adders, carry-in = 1.
- N = D[63]; V = (A[63] == ~B[63]) && (D[63] != A[63]), i.e. signed overflow of A − B.
- lt = N XOR V. This gives the correct result across the whole range, including overflowing cases (A = −2^63, B = positive; A = 2^63−1, B = negative).
- A == B → D = 0, N = 0, V = 0 → lt = 0.
- Y_next = {63'b0, lt}. Bits 63:1 of Y are constant 0 at all times, including during and after reset.
- No X-propagation special handling: inputs are assumed driven; the block does not detect X/Z.
- No internal state besides the Y register; no handshake, no enable.

## Timing
- Latency: exactly 1 cycle. A and B sampled at rising edge k; Y reflects them from edge k onward and is stable until the next edge.
- Inputs changing between edges have no effect until the next rising edge.
- Reset: when reset = 1 at a rising edge, Y <= 64'b0 regardless of A/B. Reset has priority over the update.
- Reset released at edge k (reset = 0 sampled at k): Y at edge k takes the comparison of A/B sampled at k.
- Reset asserted mid-stream discards the in-flight result; no recovery state needed.
- Value of Y before the first rising edge is undefined; bench must apply reset for ≥ 1 cycle.
- Combinational path A/B → D → lt is a 64-bit ripple chain; it must meet one clock period of the ALU clock, no pipelining inside.

## Structure
- Shared ALU package: WIDTH = 64 constant, and the result-zero-extension convention (bit 0 carries the flag, upper bits 0) reused by the sltu/compare units.
- One sub-module: full_adder (a, b, cin → sum, cout), instantiated WIDTH times via generate to form the subtractor; top-level slt holds operand inversion, carry-in tie-off, overflow/sign logic and the Y register.
- No FSM.

## Test plan
- Reset: hold reset = 1 for 2 cycles with A = −5, B = 3 → Y = 0 during reset; first cycle after release → Y = 1.
- Basic set: A = 10, B = 5 → Y = 0; A = −5, B = 3 → Y = 1; A = −10, B = −20 → Y = 0; A = −10, B = −5 → Y = 1; each checked one cycle after applying.
- Equality: A = B = 0, A = B = −1, A = B = 2^63−1 → Y = 0 in all cases.
- Overflow corners: A = −2^63, B = 1 → Y = 1; A = 2^63−1, B = −1 → Y = 0; A = −2^63, B = 2^63−1 → Y = 1; A = 2^63−1, B = −2^63 → Y = 0.
- Latency: change A/B every cycle over 8 cycles alternating lt/not-lt pairs → Y toggles 1/0 exactly one cycle behind inputs; Y[63:1] always 0.
- Random: 10,000 random signed pairs vs. reference $signed(A) < $signed(B), checked with 1-cycle delay, with reset pulses inserted randomly → Y = 0 on the cycle after each reset edge.
